// File: rtl/inst_enc_pkg.sv
// inst_enc_pkg
//   Constants shared by the instruction encoder and the main-control opcode
//   decoder: request kind codes, MIPS primary opcodes and the encoder FSM
//   state type.
package inst_enc_pkg;

  // Request kinds presented on in_kind
  localparam logic [2:0] KIND_R     = 3'd0;
  localparam logic [2:0] KIND_LW    = 3'd1;
  localparam logic [2:0] KIND_SW    = 3'd2;
  localparam logic [2:0] KIND_BEQ   = 3'd3;
  localparam logic [2:0] KIND_J     = 3'd4;
  localparam logic [2:0] KIND_ADDIU = 3'd5;

  // MIPS primary opcodes (bits 31:26)
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_ADDIU = 6'h09;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/inst_enc_word.sv
// inst_enc_word
//   Purely combinational encoder: request kind plus register/immediate fields
//   in, 32-bit MIPS instruction word out. Unsupported kinds (6, 7) encode as
//   32'h0000_0000 (nop) and raise illegal.
// Ports
//   kind    in  3   request kind (KIND_* codes)
//   rs/rt/rd in 5   register fields
//   funct   in  6   R-type function code
//   imm     in  16  I-type immediate
//   target  in  26  J-type target
//   word    out 32  encoded instruction
//   illegal out 1   kind is not a supported encoding
module inst_enc_word
  import inst_enc_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word,
  output logic        illegal
);

  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    case (kind)
      KIND_R:     word = {OP_RTYPE, rs, rt, rd, 5'h00, funct};
      KIND_LW:    word = {OP_LW, rs, rt, imm};
      KIND_SW:    word = {OP_SW, rs, rt, imm};
      KIND_BEQ:   word = {OP_BEQ, rs, rt, imm};
      KIND_J:     word = {OP_J, target};
      KIND_ADDIU: word = {OP_ADDIU, rs, rt, imm};
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder
//   Turns field-level instruction requests into 32-bit MIPS words and writes
//   them sequentially into instruction memory starting at address 0.
//   Optional macro INST_ENC_ILLEGAL_CHK_EN: unsupported kinds are consumed
//   without a write and flagged on err for one cycle; otherwise they are
//   written as nop and counted.
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   start, finish       begin program at address 0 / end program
//   in_valid, in_ready  request handshake (in_ready is combinational)
//   in_kind, in_rs, in_rt, in_rd, in_funct, in_imm, in_target  request fields
//   im_wen, im_addr, im_wdata  registered instruction-memory write port
//   busy, done          FSM in RUN / DONE
//   count               words written in the current program
//   err                 (macro only) one-cycle pulse for a dropped request
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              im_wen,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              busy,
  output logic              done,
`ifdef INST_ENC_ILLEGAL_CHK_EN
  output logic              err,
`endif
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  state_t            state_reg, state_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic              wen_reg, wen_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic              err_reg, err_next;

  logic [31:0]       word;
  logic              illegal;
  logic              accept;
  logic              drop;
  logic [ADDR_W:0]   count_inc;

  inst_enc_word u_word (
    .kind    (in_kind),
    .rs      (in_rs),
    .rt      (in_rt),
    .rd      (in_rd),
    .funct   (in_funct),
    .imm     (in_imm),
    .target  (in_target),
    .word    (word),
    .illegal (illegal)
  );

`ifdef INST_ENC_ILLEGAL_CHK_EN
  // Unsupported kinds complete the handshake but never reach memory
  assign drop = illegal;
  assign err  = err_reg;
`else
  logic illegal_unused;
  assign illegal_unused = illegal;
  assign drop = 1'b0;
`endif

  // A start in RUN takes priority over any request that cycle
  assign in_ready  = (state_reg == ST_RUN) && !start && (count_reg < DEPTH_CNT);
  assign accept    = in_valid && in_ready;
  assign count_inc = count_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    wen_next   = 1'b0;
    err_next   = 1'b0;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_RUN;
          count_next = '0;
        end
      end
      ST_RUN: begin
        if (start) begin
          count_next = '0;
        end else begin
          if (accept) begin
            err_next = drop;
            if (!drop) begin
              wen_next   = 1'b1;
              addr_next  = count_reg[ADDR_W-1:0];
              wdata_next = word;
              count_next = count_inc;
            end
          end
          // The last accepted word lands before DONE since the write is registered
          if (finish || (accept && !drop && (count_inc == DEPTH_CNT)))
            state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_next = ST_RUN;
          count_next = '0;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      count_reg <= '0;
      wen_reg   <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      wen_reg   <= wen_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      err_reg   <= err_next;
    end
  end

  assign im_wen   = wen_reg;
  assign im_addr  = addr_reg;
  assign im_wdata = wdata_reg;
  assign count    = count_reg;
  assign busy     = (state_reg == ST_RUN);
  assign done     = (state_reg == ST_DONE);

endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder
//   Directed bench for inst_encoder: a DEPTH=256 instance for the main
//   program flow and a DEPTH=4 instance for the capacity boundary.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, finish, in_valid;
  logic        start4, finish4, in_valid4;
  logic [2:0]  in_kind;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  logic        in_ready, im_wen, busy, done;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic [8:0]  count;

  logic        in_ready4, im_wen4, busy4, done4;
  logic [1:0]  im_addr4;
  logic [31:0] im_wdata4;
  logic [2:0]  count4;
`ifdef INST_ENC_ILLEGAL_CHK_EN
  logic        err, err4;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(8), .DEPTH(256)) dut (
    .clk(clk), .rst(rst), .start(start), .finish(finish),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target),
    .im_wen(im_wen), .im_addr(im_addr), .im_wdata(im_wdata),
    .busy(busy), .done(done),
`ifdef INST_ENC_ILLEGAL_CHK_EN
    .err(err),
`endif
    .count(count)
  );

  inst_encoder #(.ADDR_W(2), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .finish(finish4),
    .in_valid(in_valid4), .in_ready(in_ready4), .in_kind(in_kind),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_funct(in_funct),
    .in_imm(in_imm), .in_target(in_target),
    .im_wen(im_wen4), .im_addr(im_addr4), .im_wdata(im_wdata4),
    .busy(busy4), .done(done4),
`ifdef INST_ENC_ILLEGAL_CHK_EN
    .err(err4),
`endif
    .count(count4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [5:0] fn, input logic [15:0] im,
                         input logic [25:0] tg);
    in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
    in_funct = fn; in_imm = im; in_target = tg;
  endtask

  // Back-to-back program: kinds, fields and hand-computed words
  logic [2:0]  seq_kind [5]  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
  logic [4:0]  seq_rs   [5]  = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0};
  logic [4:0]  seq_rt   [5]  = '{5'd2, 5'd2, 5'd2, 5'd0, 5'd1};
  logic [15:0] seq_imm  [5]  = '{16'h0004, 16'h0008, 16'hFFFF, 16'h0000, 16'h0005};
  logic [25:0] seq_tg   [5]  = '{26'h0, 26'h0, 26'h0, 26'h10, 26'h0};
  logic [31:0] seq_word [5]  = '{32'h8C22_0004, 32'hAC22_0008, 32'h1022_FFFF,
                                 32'h0800_0010, 32'h2401_0005};

  initial begin
    rst = 1'b1;
    start = 0; finish = 0; in_valid = 0;
    start4 = 0; finish4 = 0; in_valid4 = 0;
    set_req(3'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);

    // Reset state
    tick();
    check("rst_wen", {31'd0, im_wen}, 32'd0);
    check("rst_addr", {24'd0, im_addr}, 32'd0);
    check("rst_wdata", im_wdata, 32'd0);
    check("rst_count", {23'd0, count}, 32'd0);
    check("rst_busy_done_rdy", {29'd0, busy, done, in_ready}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_ready", {31'd0, in_ready}, 32'd0);

    // Start program
    start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("run_busy", {31'd0, busy}, 32'd1);
    check("run_ready", {31'd0, in_ready}, 32'd1);

    // R-type addu $3,$1,$2
    set_req(3'd0, 5'd1, 5'd2, 5'd3, 6'h21, 16'd0, 26'd0);
    in_valid = 1'b1;
    tick();
    check("r_wen", {31'd0, im_wen}, 32'd1);
    check("r_addr", {24'd0, im_addr}, 32'd0);
    check("r_data", im_wdata, 32'h0022_1821);

    // Back-to-back I/J-type words, one per cycle
    for (int i = 0; i < 5; i++) begin
      set_req(seq_kind[i], seq_rs[i], seq_rt[i], 5'd0, 6'd0, seq_imm[i], seq_tg[i]);
      tick();
      check($sformatf("seq%0d_wen", i), {31'd0, im_wen}, 32'd1);
      check($sformatf("seq%0d_addr", i), {24'd0, im_addr}, i + 1);
      check($sformatf("seq%0d_data", i), im_wdata, seq_word[i]);
    end
    check("seq_count", {23'd0, count}, 32'd6);
    in_valid = 1'b0;
    tick();
    check("idle_cycle_wen", {31'd0, im_wen}, 32'd0);
    check("idle_cycle_count", {23'd0, count}, 32'd6);

    // finish together with a request: word written, then DONE
    set_req(3'd5, 5'd2, 5'd3, 5'd0, 6'd0, 16'h0007, 26'd0);
    in_valid = 1'b1;
    finish = 1'b1;
    tick();
    in_valid = 1'b0;
    finish = 1'b0;
    check("fin_wen", {31'd0, im_wen}, 32'd1);
    check("fin_addr", {24'd0, im_addr}, 32'd6);
    check("fin_data", im_wdata, 32'h2443_0007);
    check("fin_done_busy", {30'd0, done, busy}, 32'd2);
    check("fin_ready", {31'd0, in_ready}, 32'd0);
    check("fin_count", {23'd0, count}, 32'd7);

    // Restart from DONE, then an unsupported kind
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_count", {23'd0, count}, 32'd0);
    set_req(3'd7, 5'd1, 5'd1, 5'd1, 6'h3F, 16'h1234, 26'h0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef INST_ENC_ILLEGAL_CHK_EN
    check("k7_err", {31'd0, err}, 32'd1);
    check("k7_wen", {31'd0, im_wen}, 32'd0);
    check("k7_count", {23'd0, count}, 32'd0);
    tick();
    check("k7_err_pulse", {31'd0, err}, 32'd0);
`else
    check("k7_wen", {31'd0, im_wen}, 32'd1);
    check("k7_data", im_wdata, 32'h0000_0000);
    check("k7_addr", {24'd0, im_addr}, 32'd0);
    check("k7_count", {23'd0, count}, 32'd1);
`endif

    // start while RUN with a request pending: request dropped, count cleared
    set_req(3'd1, 5'd4, 5'd5, 5'd0, 6'd0, 16'h0010, 26'd0);
    in_valid = 1'b1;
    start = 1'b1;
    #1;
    check("rs_ready", {31'd0, in_ready}, 32'd0);
    tick();
    start = 1'b0;
    check("rs_wen", {31'd0, im_wen}, 32'd0);
    check("rs_count", {23'd0, count}, 32'd0);
    check("rs_busy", {31'd0, busy}, 32'd1);

    // Accept LW, then async reset while its write is visible
    tick();
    in_valid = 1'b0;
    check("pre_rst_wen", {31'd0, im_wen}, 32'd1);
    check("pre_rst_data", im_wdata, 32'h8C85_0010);
    rst = 1'b1;
    #1;
    check("arst_outs", {29'd0, im_wen, busy, done}, 32'd0);
    check("arst_count", {23'd0, count}, 32'd0);
    check("arst_data", im_wdata, 32'd0);
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    set_req(3'd2, 5'd1, 5'd2, 5'd0, 6'd0, 16'h0008, 26'd0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("resume_addr", {24'd0, im_addr}, 32'd0);
    check("resume_data", im_wdata, 32'hAC22_0008);
    check("resume_wen", {31'd0, im_wen}, 32'd1);

    // DEPTH=4 instance: four accepts fill it
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    in_valid4 = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      set_req(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'(i));
      tick();
      check($sformatf("d4_%0d_addr", i), {30'd0, im_addr4}, i - 1);
    end
    check("d4_data", im_wdata4, 32'h0800_0004);
    check("d4_wen", {31'd0, im_wen4}, 32'd1);
    check("d4_done", {31'd0, done4}, 32'd1);
    check("d4_ready", {31'd0, in_ready4}, 32'd0);
    check("d4_count", {29'd0, count4}, 32'd4);
    set_req(3'd4, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd5);
    tick();
    check("d4_stall_wen", {31'd0, im_wen4}, 32'd0);
    check("d4_stall_count", {29'd0, count4}, 32'd4);
    check("d4_stall_data", im_wdata4, 32'h0800_0004);
    in_valid4 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
